// File: rtl/cursor_grid_ctrl.sv
// Grid cursor: button-driven position with frame-synchronous moves and auto-repeat,
// bracket outline on a 1-cycle pixel pipeline, and selection valid/ack. Optional blink: CURSOR_BLINK_EN.
module cursor_grid_ctrl #(
    parameter int          SIZE          = 32,
    parameter int          SIZE_LOG2     = 5,
    parameter int          H_MAX         = 640,
    parameter int          V_MAX         = 480,
    parameter int          HOME_X        = 0,
    parameter int          HOME_Y        = 0,
    parameter int          REPEAT_FRAMES = 15,
    parameter int          BLINK_FRAMES  = 30,
    parameter logic [11:0] COLOR         = 12'h000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [9:0]  i_pixel_x,
    input  logic [9:0]  i_pixel_y,
    input  logic        i_frame_tick,
    input  logic        i_btn_up,
    input  logic        i_btn_down,
    input  logic        i_btn_left,
    input  logic        i_btn_right,
    input  logic        i_sel,
    input  logic        i_sel_ack,
    output logic        o_on,
    output logic [11:0] o_color,
    output logic [9:0]  o_cur_x,
    output logic [9:0]  o_cur_y,
    output logic        o_sel_valid,
    output logic [9:0]  o_sel_cell_x,
    output logic [9:0]  o_sel_cell_y
);

    // state      | meaning
    // DIR_NONE   | no direction seen at the last frame_tick
    // DIR_UP     | up was the decoded direction at the last frame_tick
    // DIR_DOWN   | down was the decoded direction at the last frame_tick
    // DIR_LEFT   | left was the decoded direction at the last frame_tick
    // DIR_RIGHT  | right was the decoded direction at the last frame_tick
    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam int RPT_W = (REPEAT_FRAMES > 2) ? $clog2(REPEAT_FRAMES) : 1;
    localparam logic [RPT_W-1:0]     RPT_TC = RPT_W'(REPEAT_FRAMES - 1);
    localparam logic [9:0]           STEP   = 10'(SIZE);
    localparam logic [9:0]           X_LIM  = 10'(H_MAX - SIZE);
    localparam logic [9:0]           Y_LIM  = 10'(V_MAX - SIZE);
    localparam logic [SIZE_LOG2-1:0] EDGE   = SIZE_LOG2'(SIZE - 1);
    localparam logic [SIZE_LOG2-1:0] CB_LO  = SIZE_LOG2'(SIZE / 8);
    localparam logic [SIZE_LOG2-1:0] CB_HI  = SIZE_LOG2'(SIZE - SIZE / 8);

    dir_t              r_prev_dir, w_prev_dir_next, w_dir;
    logic [RPT_W-1:0]  r_rpt_cnt, w_rpt_next;
    logic              w_move;
    logic [9:0]        r_cur_x, r_cur_y, w_x_next, w_y_next;
    logic              w_pos_change;
    logic              r_on;
    logic [11:0]       r_color;
    logic              r_sel_valid;
    logic [9:0]        r_cell_x, r_cell_y;
    logic [9:0]        w_dx, w_dy;
    logic [SIZE_LOG2-1:0] w_c, w_r;
    logic              w_in_fp, w_lit, w_visible;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_prev_dir <= DIR_NONE;
            r_rpt_cnt  <= '0;
            r_cur_x    <= 10'(HOME_X);
            r_cur_y    <= 10'(HOME_Y);
        end else begin
            r_prev_dir <= w_prev_dir_next;
            r_rpt_cnt  <= w_rpt_next;
            r_cur_x    <= w_x_next;
            r_cur_y    <= w_y_next;
        end
    end

    always_comb begin
        w_dir           = DIR_NONE;
        w_prev_dir_next = r_prev_dir;
        w_rpt_next      = r_rpt_cnt;
        w_move          = 1'b0;
        w_x_next        = r_cur_x;
        w_y_next        = r_cur_y;
        if (i_btn_up)         w_dir = DIR_UP;
        else if (i_btn_down)  w_dir = DIR_DOWN;
        else if (i_btn_left)  w_dir = DIR_LEFT;
        else if (i_btn_right) w_dir = DIR_RIGHT;
        if (i_frame_tick) begin
            w_prev_dir_next = w_dir;
            if (w_dir == DIR_NONE) begin
                w_rpt_next = '0;
            end else if (w_dir != r_prev_dir || r_rpt_cnt == RPT_TC) begin
                w_move     = 1'b1;
                w_rpt_next = '0;
            end else begin
                w_rpt_next = r_rpt_cnt + 1'b1;
            end
        end
        // Blocked moves still consume the repeat slot; only the position saturates.
        if (w_move) begin
            case (w_dir)
                DIR_UP:    if (r_cur_y >= STEP)  w_y_next = r_cur_y - STEP;
                DIR_DOWN:  if (r_cur_y <  Y_LIM) w_y_next = r_cur_y + STEP;
                DIR_LEFT:  if (r_cur_x >= STEP)  w_x_next = r_cur_x - STEP;
                DIR_RIGHT: if (r_cur_x <  X_LIM) w_x_next = r_cur_x + STEP;
                default:   ;
            endcase
        end
    end

    assign w_pos_change = (w_x_next != r_cur_x) || (w_y_next != r_cur_y);

`ifdef CURSOR_BLINK_EN
    localparam int BLK_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLK_W-1:0] BLK_TC = BLK_W'(BLINK_FRAMES - 1);

    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_visible;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_blink_cnt <= '0;
            r_visible   <= 1'b1;
        end else if (i_frame_tick) begin
            if (w_pos_change) begin
                r_blink_cnt <= '0;
                r_visible   <= 1'b1;
            end else if (r_blink_cnt == BLK_TC) begin
                r_blink_cnt <= '0;
                r_visible   <= ~r_visible;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_visible = r_visible;
`else
    logic w_unused_blink;
    assign w_unused_blink = (BLINK_FRAMES > 0) & w_pos_change;
    assign w_visible      = 1'b1;
`endif

    assign w_dx    = i_pixel_x - r_cur_x;
    assign w_dy    = i_pixel_y - r_cur_y;
    assign w_c     = w_dx[SIZE_LOG2-1:0];
    assign w_r     = w_dy[SIZE_LOG2-1:0];
    assign w_in_fp = (i_pixel_x >= r_cur_x) && (w_dx < STEP) &&
                     (i_pixel_y >= r_cur_y) && (w_dy < STEP);
    assign w_lit   = (w_r == '0) || (w_r == EDGE) || (w_c == '0) || (w_c == EDGE) ||
                     (((w_r < CB_LO) || (w_r >= CB_HI)) && ((w_c < CB_LO) || (w_c >= CB_HI)));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_on    <= 1'b0;
            r_color <= 12'h000;
        end else begin
            r_on    <= w_in_fp & w_lit & w_visible;
            r_color <= (w_in_fp & w_lit & w_visible) ? COLOR : 12'h000;
        end
    end

    // Capture uses the registered position, so a same-cycle move is not seen.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sel_valid <= 1'b0;
            r_cell_x    <= '0;
            r_cell_y    <= '0;
        end else if (r_sel_valid) begin
            if (i_sel_ack) begin
                r_sel_valid <= i_sel;
                if (i_sel) begin
                    r_cell_x <= r_cur_x >> SIZE_LOG2;
                    r_cell_y <= r_cur_y >> SIZE_LOG2;
                end
            end
        end else if (i_sel) begin
            r_sel_valid <= 1'b1;
            r_cell_x    <= r_cur_x >> SIZE_LOG2;
            r_cell_y    <= r_cur_y >> SIZE_LOG2;
        end
    end

    assign o_on         = r_on;
    assign o_color      = r_color;
    assign o_cur_x      = r_cur_x;
    assign o_cur_y      = r_cur_y;
    assign o_sel_valid  = r_sel_valid;
    assign o_sel_cell_x = r_cell_x;
    assign o_sel_cell_y = r_cell_y;

endmodule

// File: tb/tb_cursor_grid_ctrl.sv
// Directed bench for cursor_grid_ctrl: pixel-shape table plus hand sequences for moves,
// saturation, selection handshake, async reset and blink (CURSOR_BLINK_EN aware).
module tb_cursor_grid_ctrl;

    localparam logic [11:0] TB_COLOR = 12'hABC;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [9:0]  i_pixel_x, i_pixel_y;
    logic        i_frame_tick, i_btn_up, i_btn_down, i_btn_left, i_btn_right;
    logic        i_sel, i_sel_ack;
    logic        o_on, o_sel_valid;
    logic [11:0] o_color;
    logic [9:0]  o_cur_x, o_cur_y, o_sel_cell_x, o_sel_cell_y;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic       exp_on;
    } pix_vec_t;

    pix_vec_t vecs[13];

    cursor_grid_ctrl #(.COLOR(TB_COLOR)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_pixel_x(i_pixel_x), .i_pixel_y(i_pixel_y),
        .i_frame_tick(i_frame_tick),
        .i_btn_up(i_btn_up), .i_btn_down(i_btn_down),
        .i_btn_left(i_btn_left), .i_btn_right(i_btn_right),
        .i_sel(i_sel), .i_sel_ack(i_sel_ack),
        .o_on(o_on), .o_color(o_color),
        .o_cur_x(o_cur_x), .o_cur_y(o_cur_y),
        .o_sel_valid(o_sel_valid),
        .o_sel_cell_x(o_sel_cell_x), .o_sel_cell_y(o_sel_cell_y)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic frame(input logic u, input logic d, input logic l, input logic r);
        i_btn_up = u; i_btn_down = d; i_btn_left = l; i_btn_right = r;
        i_frame_tick = 1'b1;
        step();
        i_frame_tick = 1'b0;
        i_btn_up = 0; i_btn_down = 0; i_btn_left = 0; i_btn_right = 0;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        i_frame_tick = 0; i_sel = 0; i_sel_ack = 0;
        i_btn_up = 0; i_btn_down = 0; i_btn_left = 0; i_btn_right = 0;
        step();
        step();
        i_reset_n = 1'b1;
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic exp_on, input string name);
        i_pixel_x = x;
        i_pixel_y = y;
        step();
        check({name, ".on"}, 32'(o_on), 32'(exp_on));
        check({name, ".color"}, 32'(o_color), exp_on ? 32'(TB_COLOR) : 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{10'd0,   10'd0,   1'b1};
        vecs[1]  = '{10'd16,  10'd16,  1'b0};
        vecs[2]  = '{10'd2,   10'd2,   1'b1};
        vecs[3]  = '{10'd31,  10'd0,   1'b1};
        vecs[4]  = '{10'd31,  10'd31,  1'b1};
        vecs[5]  = '{10'd32,  10'd0,   1'b0};
        vecs[6]  = '{10'd0,   10'd31,  1'b1};
        vecs[7]  = '{10'd5,   10'd5,   1'b0};
        vecs[8]  = '{10'd3,   10'd28,  1'b1};
        vecs[9]  = '{10'd4,   10'd28,  1'b0};
        vecs[10] = '{10'd15,  10'd1,   1'b0};
        vecs[11] = '{10'd0,   10'd479, 1'b0};
        vecs[12] = '{10'd29,  10'd30,  1'b1};

        i_pixel_x = 10'd100;
        i_pixel_y = 10'd100;
        do_reset();

        check("rst.cur_x", 32'(o_cur_x), 0);
        check("rst.cur_y", 32'(o_cur_y), 0);
        check("rst.on", 32'(o_on), 0);
        check("rst.color", 32'(o_color), 0);
        check("rst.sel_valid", 32'(o_sel_valid), 0);

        for (int i = 0; i < 13; i++)
            pix(vecs[i].px, vecs[i].py, vecs[i].exp_on, $sformatf("pix%0d", i));

        // Pixel path is registered: output must not follow the input before the edge.
        pix(10'd0, 10'd0, 1'b1, "lat.pre");
        i_pixel_x = 10'd16;
        i_pixel_y = 10'd16;
        #2;
        check("lat.hold", 32'(o_on), 1);
        step();
        check("lat.after", 32'(o_on), 0);

        do_reset();
        frame(0, 0, 0, 1);
        check("tap.cur_x", 32'(o_cur_x), 32);
        do_reset();
        repeat (16) frame(0, 0, 0, 1);
        check("hold16.cur_x", 32'(o_cur_x), 64);
        repeat (15) frame(0, 0, 0, 1);
        check("hold31.cur_x", 32'(o_cur_x), 96);
        i_btn_right = 1'b1;
        repeat (5) step();
        i_btn_right = 1'b0;
        check("no_tick.cur_x", 32'(o_cur_x), 96);
        pix(10'd95, 10'd0, 1'b0, "fp.left");
        pix(10'd96, 10'd0, 1'b1, "fp.tl");
        pix(10'd127, 10'd31, 1'b1, "fp.br");
        pix(10'd128, 10'd0, 1'b0, "fp.right");

        do_reset();
        for (int i = 0; i < 19; i++) begin
            frame(0, 0, 0, 1);
            if (i < 14) frame(0, 1, 0, 0);
            else        frame(0, 0, 0, 0);
        end
        check("corner.cur_x", 32'(o_cur_x), 608);
        check("corner.cur_y", 32'(o_cur_y), 448);
        for (int i = 0; i < 4; i++) begin
            frame(0, 0, 0, 1);
            frame(0, 1, 0, 0);
        end
        check("sat_alt.cur_x", 32'(o_cur_x), 608);
        check("sat_alt.cur_y", 32'(o_cur_y), 448);
        repeat (20) frame(0, 0, 0, 1);
        check("sat_hold.cur_x", 32'(o_cur_x), 608);
        frame(1, 0, 1, 0);
        check("prio.cur_x", 32'(o_cur_x), 608);
        check("prio.cur_y", 32'(o_cur_y), 416);

        do_reset();
        frame(0, 0, 0, 1);
        frame(0, 1, 0, 0);
        frame(0, 0, 0, 1);
        frame(0, 1, 0, 0);
        frame(0, 0, 0, 0);
        frame(0, 1, 0, 0);
        check("sel.cur_x", 32'(o_cur_x), 64);
        check("sel.cur_y", 32'(o_cur_y), 96);
        i_sel = 1; step(); i_sel = 0;
        check("sel1.valid", 32'(o_sel_valid), 1);
        check("sel1.cell_x", 32'(o_sel_cell_x), 2);
        check("sel1.cell_y", 32'(o_sel_cell_y), 3);
        frame(0, 0, 0, 1);
        check("sel2.cur_x", 32'(o_cur_x), 96);
        i_sel = 1; step(); i_sel = 0;
        check("sel2.valid", 32'(o_sel_valid), 1);
        check("sel2.cell_x", 32'(o_sel_cell_x), 2);
        check("sel2.cell_y", 32'(o_sel_cell_y), 3);
        i_sel_ack = 1; step(); i_sel_ack = 0;
        check("ack.valid", 32'(o_sel_valid), 0);
        i_sel_ack = 1; step(); i_sel_ack = 0;
        check("ack_idle.valid", 32'(o_sel_valid), 0);
        i_sel = 1; step(); i_sel = 0;
        check("sel3.cell_x", 32'(o_sel_cell_x), 3);
        check("sel3.cell_y", 32'(o_sel_cell_y), 3);
        frame(0, 1, 0, 0);
        i_sel = 1; i_sel_ack = 1; step(); i_sel = 0; i_sel_ack = 0;
        check("selack.valid", 32'(o_sel_valid), 1);
        check("selack.cell_x", 32'(o_sel_cell_x), 3);
        check("selack.cell_y", 32'(o_sel_cell_y), 4);
        frame(1, 0, 0, 0);
        i_sel_ack = 1; step(); i_sel_ack = 0;
        check("ack2.valid", 32'(o_sel_valid), 0);
        i_sel = 1; i_btn_left = 1; i_frame_tick = 1;
        step();
        i_sel = 0; i_btn_left = 0; i_frame_tick = 0;
        check("selmove.cell_x", 32'(o_sel_cell_x), 3);
        check("selmove.cell_y", 32'(o_sel_cell_y), 3);
        check("selmove.cur_x", 32'(o_cur_x), 64);

        do_reset();
        frame(0, 0, 0, 1);
        i_sel = 1; step(); i_sel = 0;
        pix(10'd32, 10'd0, 1'b1, "arst.pre");
        i_btn_right = 1;
        #2;
        i_reset_n = 0;
        #1;
        check("arst.cur_x", 32'(o_cur_x), 0);
        check("arst.valid", 32'(o_sel_valid), 0);
        check("arst.cell_x", 32'(o_sel_cell_x), 0);
        check("arst.on", 32'(o_on), 0);
        check("arst.color", 32'(o_color), 0);
        step();
        i_reset_n = 1;
        i_btn_right = 0;
        frame(0, 0, 0, 0);
        check("arst.idle_x", 32'(o_cur_x), 0);
        frame(0, 0, 0, 1);
        check("arst.held_x", 32'(o_cur_x), 32);

        do_reset();
        i_pixel_x = 10'd0;
        i_pixel_y = 10'd0;
        repeat (29) frame(0, 0, 0, 0);
        step();
        check("blink.t29", 32'(o_on), 1);
        frame(0, 0, 0, 0);
        step();
`ifdef CURSOR_BLINK_EN
        check("blink.t30", 32'(o_on), 0);
`else
        check("blink.t30", 32'(o_on), 1);
`endif
        repeat (9) frame(0, 0, 0, 0);
        frame(0, 0, 0, 1);
        i_pixel_x = 10'd32;
        step();
        check("blink.move_vis", 32'(o_on), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
